// File: rtl/jtldtest_patgen.sv
// Pattern generator for the SDRAM tester: a write pass of LFSR bytes, then a check pass replaying them.
// Define JTLDTEST_LOOP_EN to repeat write/check cycles with a new seed each time until reset.
module jtldtest_patgen #(
  parameter logic [25:0] END_ADDR = 26'h200_0000,
  parameter int unsigned WR_GAP   = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned PH_GAP   = 4
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        start,
  input  logic        dwnld_busy,
  output logic        downloading,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr,
  output logic        phase,
  output logic        done,
  output logic [7:0]  loops
);

  localparam int unsigned PMAX = (WR_GAP > PH_GAP) ? WR_GAP : PH_GAP;
  localparam int unsigned CW   = (PMAX > 2) ? $clog2(PMAX) : 1;
  localparam logic [CW-1:0] WR_RELOAD = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] PH_RELOAD = CW'(PH_GAP - 1);
  // END_ADDR may be 2^25, so the last address is computed in 26 bits first
  localparam logic [25:0] LAST_FULL = END_ADDR - 26'd1;
  localparam logic [24:0] LAST_ADDR = LAST_FULL[24:0];

  typedef enum logic [2:0] {
    S_IDLE, S_WR_RUN, S_WR_TAIL, S_GAP, S_CK_RUN, S_CK_TAIL, S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] pace_q;
  logic [24:0]   addr_cnt_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [15:0]   seed_cur_q;
  logic          downloading_q;
  logic [24:0]   ioctl_addr_q;
  logic [7:0]    ioctl_dout_q;
  logic          ioctl_wr_q;
  logic          phase_q;
  logic          done_q;
  logic [7:0]    loops_q;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

`ifdef JTLDTEST_LOOP_EN
  logic [15:0] seed_step;
  logic [15:0] seed_d;
  assign seed_step = {seed_cur_q[14:0], seed_cur_q[15] ^ seed_cur_q[13]};
  assign seed_d    = (seed_step == 16'h0000) ? SEED : seed_step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pace_q        <= '0;
      addr_cnt_q    <= '0;
      lfsr_q        <= SEED;
      seed_cur_q    <= SEED;
      downloading_q <= 1'b0;
      ioctl_addr_q  <= '0;
      ioctl_dout_q  <= '0;
      ioctl_wr_q    <= 1'b0;
      phase_q       <= 1'b0;
      done_q        <= 1'b0;
      loops_q       <= '0;
    end else begin
      ioctl_wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= S_WR_RUN;
            addr_cnt_q    <= '0;
            lfsr_q        <= seed_cur_q;
            pace_q        <= WR_RELOAD;
            downloading_q <= 1'b1;
            phase_q       <= 1'b0;
          end
        end
        S_WR_RUN, S_CK_RUN: begin
          if (pace_q != '0) begin
            pace_q <= pace_q - 1'b1;
          end else if (!dwnld_busy) begin
            // a stalled strobe waits here with the counter at 0, so nothing is skipped
            ioctl_wr_q   <= 1'b1;
            ioctl_addr_q <= addr_cnt_q;
            ioctl_dout_q <= lfsr_q[7:0];
            lfsr_q       <= lfsr_d;
            addr_cnt_q   <= addr_cnt_q + 25'd1;
            pace_q       <= WR_RELOAD;
            if (addr_cnt_q == LAST_ADDR)
              state_q <= (state_q == S_WR_RUN) ? S_WR_TAIL : S_CK_TAIL;
          end
        end
        S_WR_TAIL: begin
          if (pace_q != '0) begin
            pace_q <= pace_q - 1'b1;
          end else begin
            state_q       <= S_GAP;
            downloading_q <= 1'b0;
            phase_q       <= 1'b1;
            pace_q        <= PH_RELOAD;
          end
        end
        S_GAP: begin
          if (pace_q != '0) begin
            pace_q <= pace_q - 1'b1;
          end else begin
            // phase tells which pass follows the gap
            state_q       <= phase_q ? S_CK_RUN : S_WR_RUN;
            addr_cnt_q    <= '0;
            lfsr_q        <= seed_cur_q;
            pace_q        <= WR_RELOAD;
            downloading_q <= 1'b1;
          end
        end
        S_CK_TAIL: begin
          if (pace_q != '0) begin
            pace_q <= pace_q - 1'b1;
          end else begin
            loops_q       <= loops_q + 8'd1;
            downloading_q <= 1'b0;
            phase_q       <= 1'b0;
`ifdef JTLDTEST_LOOP_EN
            state_q       <= S_GAP;
            pace_q        <= PH_RELOAD;
            seed_cur_q    <= seed_d;
`else
            state_q       <= S_DONE;
            done_q        <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          if (!start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign downloading = downloading_q;
  assign ioctl_addr  = ioctl_addr_q;
  assign ioctl_dout  = ioctl_dout_q;
  assign ioctl_wr    = ioctl_wr_q;
  assign phase       = phase_q;
  assign done        = done_q;
  assign loops       = loops_q;

endmodule

// File: tb/tb_jtldtest_patgen.sv
// Directed bench for jtldtest_patgen: END_ADDR=4, WR_GAP=2, PH_GAP=4, seed ACE1.
module tb_jtldtest_patgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dwnld_busy;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        phase;
  logic        done;
  logic [7:0]  loops;

  jtldtest_patgen #(
    .END_ADDR(26'd4),
    .WR_GAP  (2),
    .SEED    (16'hACE1),
    .PH_GAP  (4)
  ) dut (
    .rst        (rst),
    .clk        (clk),
    .start      (start),
    .dwnld_busy (dwnld_busy),
    .downloading(downloading),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .ioctl_wr   (ioctl_wr),
    .phase      (phase),
    .done       (done),
    .loops      (loops)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_str    = 0;
  int gap_cnt  = 0;
  int dbl_wr   = 0;
  logic wr_prev = 1'b0;
  logic [24:0] s_addr  [64];
  logic [7:0]  s_dout  [64];
  logic        s_phase [64];
  int          s_cyc   [64];

  // ACE1 through the right-shifting Galois LFSR (mask B400): E1 -> 70 -> 38 -> 9C
  logic [7:0] exp_dout [4] = '{8'hE1, 8'h70, 8'h38, 8'h9C};

  // strobe recorder, one line per strobe
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ioctl_wr) begin
      if (n_str < 64) begin
        s_addr[n_str]  = ioctl_addr;
        s_dout[n_str]  = ioctl_dout;
        s_phase[n_str] = phase;
        s_cyc[n_str]   = cyc;
      end
      $display("strobe %0d: cyc=%0d addr=%0h dout=%02h phase=%0d", n_str, cyc, ioctl_addr, ioctl_dout, phase);
      n_str = n_str + 1;
    end
    if (ioctl_wr && wr_prev) dbl_wr = dbl_wr + 1;
    wr_prev = ioctl_wr;
    if (!downloading && phase) gap_cnt = gap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_str < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(n_str), 32'(target));
  endtask

  task automatic check_pass(input string nm, input int base);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 32'(s_addr[base+i]), 32'(i % 4));
      chk($sformatf("%s_dout%0d", nm, i), 32'(s_dout[base+i]), 32'(exp_dout[i%4]));
      chk($sformatf("%s_phase%0d", nm, i), 32'(s_phase[base+i]), 32'(i / 4));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_downloading"}, 32'(downloading), 32'd0);
    chk({nm, "_wr"},          32'(ioctl_wr),    32'd0);
    chk({nm, "_addr"},        32'(ioctl_addr),  32'd0);
    chk({nm, "_dout"},        32'(ioctl_dout),  32'd0);
    chk({nm, "_phase"},       32'(phase),       32'd0);
    chk({nm, "_done"},        32'(done),        32'd0);
    chk({nm, "_loops"},       32'(loops),       32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    start = 1'b0;
    dwnld_busy = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // basic write + check, start pulsed
    base = n_str;
    gap_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    chk("t1_count", 32'(n_str - base), 32'd8);
    check_pass("t1", base);
    chk("t1_wr_spacing", 32'(s_cyc[base+1] - s_cyc[base]), 32'd2);
    chk("t1_ck_spacing", 32'(s_cyc[base+5] - s_cyc[base+4]), 32'd2);
    chk("t1_gap_len", 32'(gap_cnt), 32'd4);
    chk("t1_loops", 32'(loops), 32'd1);
    chk("t1_phase_done", 32'(phase), 32'd0);
    tick();
    chk("t1_idle_done", 32'(done), 32'd0);

    // stalls: long stall before addr 2, short stall on the final strobe; start held high
    base = n_str;
    start = 1'b1;
    wait_strobes("t2_reach_a1", base + 2, 100);
    dwnld_busy = 1'b1;
    repeat (10) tick();
    chk("t2_held_off", 32'(n_str - base), 32'd2);
    dwnld_busy = 1'b0;
    tick();
    chk("t2_release_strobe", 32'(n_str - base), 32'd3);
    wait_strobes("t2_reach_ck_a2", base + 7, 100);
    dwnld_busy = 1'b1;
    repeat (3) tick();
    chk("t2_last_held", 32'(n_str - base), 32'd7);
    dwnld_busy = 1'b0;
    wait_done(200);
    chk("t2_count", 32'(n_str - base), 32'd8);
    check_pass("t2", base);
    repeat (5) tick();
    chk("t2_no_retrigger_done", 32'(done), 32'd1);
    chk("t2_no_retrigger_str", 32'(n_str - base), 32'd8);
    chk("t2_loops", 32'(loops), 32'd2);
    start = 1'b0;
    tick();
    chk("t2_idle_done", 32'(done), 32'd0);

    // reset during the check pass
    base = n_str;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_strobes("t3_reach_ck_a1", base + 6, 100);
    chk("t3_ck_phase", 32'(s_phase[base+5]), 32'd1);
    chk("t3_ck_addr", 32'(s_addr[base+5]), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t3_rst");
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("t3_no_strobes", 32'(n_str - base), 32'd6);
    chk("t3_downloading", 32'(downloading), 32'd0);

    chk("single_clock_wr", 32'(dbl_wr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
